// File: rtl/hilo_unit_pkg.sv
// Shared HI/LO unit definitions: ALUOP codes, state encodings,
// default latencies and opcode classification helpers.
package hilo_unit_pkg;

  localparam logic [4:0] ALUOP_MULT  = 5'h18;
  localparam logic [4:0] ALUOP_MULTU = 5'h19;
  localparam logic [4:0] ALUOP_DIV   = 5'h1A;
  localparam logic [4:0] ALUOP_DIVU  = 5'h1B;

  typedef enum logic {
    HILO_IDLE = 1'b0,
    HILO_BUSY = 1'b1
  } hilo_state_e;

  localparam int HILO_MULT_LAT = 4;
  localparam int HILO_DIV_LAT  = 32;

  function automatic logic is_muldiv(
    input logic [4:0] op
  );
    return (op == ALUOP_MULT) || (op == ALUOP_MULTU) ||
           (op == ALUOP_DIV)  || (op == ALUOP_DIVU);
  endfunction

  function automatic logic is_div(
    input logic [4:0] op
  );
    return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_regfile.sv
// Architectural HI/LO registers with independent write
// enables and a prioritised (HI first) read mux.
module hilo_regfile (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] hi_wdata_i,
  input  logic [31:0] lo_wdata_i,
  input  logic        rd_hi_i,
  input  logic        rd_lo_i,
  output logic [31:0] rdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // HI/LO storage, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= hi_wdata_i;
      if (lo_we_i) lo_q <= lo_wdata_i;
    end
  end

  // read mux, HI wins when both are requested
  always_comb begin
    rdata_o = '0;
    if (rd_hi_i)      rdata_o = hi_q;
    else if (rd_lo_i) rdata_o = lo_q;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO owner: tracks mult/div latency, commits results,
// serves MF/MT and stalls execute on HI/LO hazards.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int MULT_LAT = HILO_MULT_LAT,
  parameter int DIV_LAT  = HILO_DIV_LAT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  input  logic [4:0]  aluop_i,
  input  logic [63:0] aluout_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] rs_data_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic        mfhi_i,
  input  logic        mflo_i,
  input  logic        flush_i,
  output logic [31:0] hilo_rdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o,
  output logic        div0_o
);

  localparam logic [5:0] MULT_CNT = 6'(MULT_LAT - 1);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT - 1);

  hilo_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pdiv0_q, pdiv0_d;
  logic        div0_q, div0_d;

  logic        md_op;
  logic        hi_we, lo_we;
  logic [31:0] hi_wd, lo_wd;

  assign md_op = is_muldiv(aluop_i);

  // FSM, counter, pending result and div0 pulse registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= HILO_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      pdiv0_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pdiv0_q <= pdiv0_d;
      div0_q  <= div0_d;
    end
  end

  // accept / count down / commit, plus MT writes when idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pdiv0_d = pdiv0_q;
    div0_d  = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_wd   = rs_data_i;
    lo_wd   = rs_data_i;
    unique case (state_q)
      HILO_IDLE: begin
        if (valid_i && !flush_i) begin
          if (md_op) begin
            state_d = HILO_BUSY;
            pend_d  = aluout_i;
            pdiv0_d = is_div(aluop_i) && (src1_i == '0);
            cnt_d   = is_div(aluop_i) ? DIV_CNT : MULT_CNT;
          end else begin
            hi_we = mthi_i;
            lo_we = mtlo_i;
          end
        end
      end
      HILO_BUSY: begin
        if (flush_i) begin
          state_d = HILO_IDLE;
          pend_d  = '0;
          pdiv0_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = HILO_IDLE;
          if (pdiv0_q) begin
            div0_d = 1'b1;
          end else begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_wd = pend_q[63:32];
            lo_wd = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = HILO_IDLE;
    endcase
  end

  assign busy_o  = (state_q == HILO_BUSY);
  assign stall_o = busy_o && valid_i &&
                   (mfhi_i || mflo_i || mthi_i || mtlo_i || md_op);
  assign div0_o  = div0_q;

  hilo_regfile u_regfile (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .hi_we_i    (hi_we),
    .lo_we_i    (lo_we),
    .hi_wdata_i (hi_wd),
    .lo_wdata_i (lo_wd),
    .rd_hi_i    (valid_i && mfhi_i),
    .rd_lo_i    (valid_i && mflo_i),
    .rdata_o    (hilo_rdata_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed scenarios plus random traffic
// checked against a completion-time reference model.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  localparam int ML = 4;
  localparam int DL = 32;

  logic        clk_i;
  logic        rst_n_i;
  logic        valid_i;
  logic [4:0]  aluop_i;
  logic [63:0] aluout_i;
  logic [31:0] src1_i;
  logic [31:0] rs_data_i;
  logic        mthi_i, mtlo_i, mfhi_i, mflo_i;
  logic        flush_i;
  logic [31:0] hilo_rdata_o, hi_o, lo_o;
  logic        busy_o, stall_o, div0_o;

  hilo_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .valid_i      (valid_i),
    .aluop_i      (aluop_i),
    .aluout_i     (aluout_i),
    .src1_i       (src1_i),
    .rs_data_i    (rs_data_i),
    .mthi_i       (mthi_i),
    .mtlo_i       (mtlo_i),
    .mfhi_i       (mfhi_i),
    .mflo_i       (mflo_i),
    .flush_i      (flush_i),
    .hilo_rdata_o (hilo_rdata_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .busy_o       (busy_o),
    .stall_o      (stall_o),
    .div0_o       (div0_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // decoder never issues MT alongside a mult/div op
  always @(posedge clk_i) begin
    if (rst_n_i && valid_i && bench_md(aluop_i))
      assert (!(mthi_i || mtlo_i))
        else $error("MT with mult/div op");
  end

  function automatic logic bench_md(input logic [4:0] op);
    return op inside {ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV, ALUOP_DIVU};
  endfunction

  // reference model: an op finishes at an absolute edge number
  logic [31:0] m_hi, m_lo;
  logic        m_busy;
  int          m_done;
  logic [63:0] m_res;
  logic        m_zero;
  logic        m_div0;
  int          edge_n = 0;

  task automatic m_reset();
    m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0;
    m_res = 0; m_zero = 0; m_div0 = 0;
  endtask

  task automatic m_step();
    int nxt;
    nxt = edge_n + 1;
    m_div0 = 0;
    if (m_busy) begin
      if (flush_i) begin
        m_busy = 0;
      end else if (nxt == m_done) begin
        m_busy = 0;
        if (m_zero) m_div0 = 1;
        else begin
          m_hi = m_res[63:32];
          m_lo = m_res[31:0];
        end
      end
    end else if (valid_i && !flush_i) begin
      if (bench_md(aluop_i)) begin
        m_busy = 1;
        m_res  = aluout_i;
        m_zero = (aluop_i == ALUOP_DIV || aluop_i == ALUOP_DIVU)
                 && src1_i == 0;
        m_done = nxt + ((aluop_i == ALUOP_DIV || aluop_i == ALUOP_DIVU)
                 ? DL : ML);
      end else begin
        if (mthi_i) m_hi = rs_data_i;
        if (mtlo_i) m_lo = rs_data_i;
      end
    end
    edge_n = nxt;
  endtask

  logic        s_busy, s_stall, s_div0;
  logic [31:0] s_rdata, s_hi, s_lo;

  task automatic check_outputs();
    logic e_stall;
    logic [31:0] e_rd;
    e_stall = m_busy && valid_i &&
              (mfhi_i || mflo_i || mthi_i || mtlo_i || bench_md(aluop_i));
    e_rd = (valid_i && mfhi_i) ? m_hi :
           (valid_i && mflo_i) ? m_lo : 32'h0;
    chk("busy",  64'(busy_o),       64'(m_busy));
    chk("stall", 64'(stall_o),      64'(e_stall));
    chk("rdata", 64'(hilo_rdata_o), 64'(e_rd));
    chk("hi",    64'(hi_o),         64'(m_hi));
    chk("lo",    64'(lo_o),         64'(m_lo));
    chk("div0",  64'(div0_o),       64'(m_div0));
  endtask

  // one clock: sample at negedge, check, predict, advance
  task automatic cycle();
    @(negedge clk_i);
    s_busy = busy_o; s_stall = stall_o; s_div0 = div0_o;
    s_rdata = hilo_rdata_o; s_hi = hi_o; s_lo = lo_o;
    check_outputs();
    m_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; aluop_i = 5'h00; aluout_i = '0; src1_i = 32'h1;
    rs_data_i = '0; mthi_i = 0; mtlo_i = 0; mfhi_i = 0; mflo_i = 0;
    flush_i = 0;
  endtask

  task automatic issue_md(input logic [4:0] op, input logic [63:0] res,
                          input logic [31:0] s1);
    idle();
    valid_i = 1; aluop_i = op; aluout_i = res; src1_i = s1;
  endtask

  task automatic issue_mt(input logic hi, input logic lo,
                          input logic [31:0] d);
    idle();
    valid_i = 1; mthi_i = hi; mtlo_i = lo; rs_data_i = d;
  endtask

  task automatic rand_inputs();
    int k;
    idle();
    valid_i = ($urandom_range(0, 3) != 0);
    k = $urandom_range(0, 9);
    aluout_i = {$urandom, $urandom};
    src1_i = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
    rs_data_i = $urandom;
    if (k < 3) begin
      aluop_i = 5'(ALUOP_MULT + 5'($urandom_range(0, 3)));
    end else begin
      aluop_i = 5'($urandom_range(0, 23));
      mthi_i = ($urandom_range(0, 3) == 0);
      mtlo_i = ($urandom_range(0, 3) == 0);
      mfhi_i = ($urandom_range(0, 3) == 0);
      mflo_i = ($urandom_range(0, 3) == 0);
    end
    flush_i = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    int n;
    int cnt;
    idle();
    m_reset();
    rst_n_i = 0;
    valid_i = 1; mfhi_i = 1;
    @(negedge clk_i);
    chk("rst_busy",  64'(busy_o),       64'h0);
    chk("rst_hi",    64'(hi_o),         64'h0);
    chk("rst_lo",    64'(lo_o),         64'h0);
    chk("rst_div0",  64'(div0_o),       64'h0);
    chk("rst_stall", 64'(stall_o),      64'h0);
    chk("rst_rdata", 64'(hilo_rdata_o), 64'h0);
    idle();
    rst_n_i = 1;
    @(posedge clk_i);
    #1;

    // MTHI then MFHI next cycle
    issue_mt(1, 0, 32'hDEAD_BEEF);
    cycle();
    idle(); valid_i = 1; mfhi_i = 1;
    cycle();
    chk("mfhi_data",  64'(s_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("mfhi_stall", 64'(s_stall), 64'h0);

    // MULT latency
    issue_md(ALUOP_MULT, 64'h0000_0001_FFFF_FFFE, 32'h3);
    cycle();
    idle();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_busy) cnt++;
    end
    chk("mult_busy_cycles", 64'(cnt), 64'(ML));
    chk("mult_hi", 64'(hi_o), 64'h1);
    chk("mult_lo", 64'(lo_o), 64'hFFFF_FFFE);

    // MFLO hazard behind DIVU
    issue_md(ALUOP_DIVU, 64'h1234_5678_9ABC_DEF0, 32'h7);
    cycle();
    idle(); valid_i = 1; mflo_i = 1;
    cnt = 0;
    n = 0;
    do begin
      cycle();
      if (s_stall) cnt++;
      n++;
    end while (s_stall && n < DL + 8);
    chk("mflo_stall_cycles", 64'(cnt), 64'(DL));
    chk("mflo_data", 64'(s_rdata), 64'h9ABC_DEF0);
    idle();
    cycle();

    // divide by zero keeps HI/LO
    issue_mt(1, 0, 32'h0000_AAAA);
    cycle();
    issue_mt(0, 1, 32'h0000_5555);
    cycle();
    issue_md(ALUOP_DIV, 64'hFFFF_0000_1111_2222, 32'h0);
    cycle();
    idle();
    cnt = 0;
    for (int i = 0; i < DL + 3; i++) begin
      cycle();
      if (s_div0) cnt++;
    end
    chk("div0_pulses", 64'(cnt), 64'h1);
    chk("div0_hi", 64'(hi_o), 64'h0000_AAAA);
    chk("div0_lo", 64'(lo_o), 64'h0000_5555);

    // flush on the commit cycle, new MULT right after
    issue_md(ALUOP_MULTU, 64'h1111_1111_2222_2222, 32'h5);
    cycle();
    idle();
    for (int i = 0; i < ML - 1; i++) cycle();
    flush_i = 1;
    cycle();
    issue_md(ALUOP_MULT, 64'h3333_3333_4444_4444, 32'h5);
    cycle();
    chk("flush_busy", 64'(s_busy), 64'h0);
    chk("flush_hi",   64'(s_hi),   64'h0000_AAAA);
    chk("flush_lo",   64'(s_lo),   64'h0000_5555);
    idle();
    for (int i = 0; i < ML + 1; i++) cycle();
    chk("remult_hi", 64'(hi_o), 64'h3333_3333);
    chk("remult_lo", 64'(lo_o), 64'h4444_4444);

    // reset in the middle of an op
    issue_md(ALUOP_MULT, 64'h5555_5555_6666_6666, 32'h9);
    cycle();
    idle();
    cycle();
    rst_n_i = 0;
    #1;
    chk("rstmid_busy", 64'(busy_o), 64'h0);
    chk("rstmid_hi",   64'(hi_o),   64'h0);
    chk("rstmid_lo",   64'(lo_o),   64'h0);
    m_reset();
    @(negedge clk_i);
    rst_n_i = 1;
    @(posedge clk_i);
    #1;
    edge_n++;
    for (int i = 0; i < ML + 3; i++) cycle();
    chk("rstmid_nocommit", 64'(hi_o), 64'h0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
